// File: rtl/rename_pkg.sv
// Shared defaults and index types for the register-rename unit.
package rename_pkg;

  localparam int ARCH_REGS_DEF = 32;
  localparam int PHYS_REGS_DEF = 64;
  localparam int AREG_W_DEF    = $clog2(ARCH_REGS_DEF);
  localparam int PREG_W_DEF    = $clog2(PHYS_REGS_DEF);

  typedef logic [AREG_W_DEF-1:0] areg_t;
  typedef logic [PREG_W_DEF-1:0] preg_t;

  localparam preg_t PREG_ZERO = {PREG_W_DEF{1'b0}};

endpackage

// File: rtl/rename_map_phys_freelist.sv
// Circular free list of physical registers. Allocation pops at head, commit pushes at tail,
// and rollback rewinds head to the oldest unretired allocation (commit_head).
module phys_freelist
  import rename_pkg::*;
#(
  parameter int DEPTH  = PHYS_REGS_DEF - ARCH_REGS_DEF,
  parameter int BASE   = ARCH_REGS_DEF,
  parameter int PREG_W = PREG_W_DEF
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              pop_i,
  input  logic              push_i,
  input  logic [PREG_W-1:0] push_data_i,
  input  logic              rollback_i,
  output logic [PREG_W-1:0] head_data_o,
  output logic [PREG_W:0]   count_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  typedef logic [PTR_W-1:0] ptr_t;
  localparam ptr_t            LAST = ptr_t'(DEPTH - 1);
  localparam logic [PREG_W:0] FULL = (PREG_W + 1)'(DEPTH);

  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == LAST) ? {PTR_W{1'b0}} : p + ptr_t'(1'b1);
  endfunction

  logic [PREG_W-1:0] fifo_q [DEPTH];
  logic [PREG_W-1:0] fifo_d [DEPTH];
  ptr_t              head_q, head_d, chead_q, chead_d, tail_q, tail_d;
  logic [PREG_W:0]   count_q, count_d;

  // Every retirement frees one register and retires one allocation, so tail and
  // commit_head advance together; after a rollback the whole list is free again.
  always_comb begin
    fifo_d  = fifo_q;
    tail_d  = push_i ? ptr_inc(tail_q) : tail_q;
    chead_d = push_i ? ptr_inc(chead_q) : chead_q;
    head_d  = rollback_i ? chead_d : (pop_i ? ptr_inc(head_q) : head_q);
    count_d = rollback_i ? FULL
                         : count_q + {{PREG_W{1'b0}}, push_i} - {{PREG_W{1'b0}}, pop_i};
    if (push_i) begin
      fifo_d[tail_q] = push_data_i;
    end else begin
      fifo_d[tail_q] = fifo_q[tail_q];
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < DEPTH; i++) fifo_q[i] <= PREG_W'(BASE + i);
      head_q  <= {PTR_W{1'b0}};
      chead_q <= {PTR_W{1'b0}};
      tail_q  <= {PTR_W{1'b0}};
      count_q <= FULL;
    end else begin
      fifo_q  <= fifo_d;
      head_q  <= head_d;
      chead_q <= chead_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign head_data_o = fifo_q[head_q];
  assign count_o     = count_q;

endmodule

// File: rtl/rename_map.sv
// Register rename: speculative RAT, committed RAT, busy table and free list.
// Optional macro RENAME_CDB_BYPASS_EN forwards a same-cycle CDB wakeup to source readiness.
module rename_map
  import rename_pkg::*;
#(
  parameter int ARCH_REGS = ARCH_REGS_DEF,
  parameter int PHYS_REGS = PHYS_REGS_DEF,
  parameter int AREG_W    = $clog2(ARCH_REGS),
  parameter int PREG_W    = $clog2(PHYS_REGS),
  parameter int FL_DEPTH  = PHYS_REGS - ARCH_REGS
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              rn_valid_i,
  output logic              rn_ready_o,
  input  logic [AREG_W-1:0] rs1_addr_i,
  input  logic [AREG_W-1:0] rs2_addr_i,
  input  logic [AREG_W-1:0] rd_addr_i,
  input  logic              rd_wen_i,
  output logic [PREG_W-1:0] prs1_addr_o,
  output logic [PREG_W-1:0] prs2_addr_o,
  output logic              prs1_rdy_o,
  output logic              prs2_rdy_o,
  output logic [PREG_W-1:0] prd_addr_o,
  output logic [PREG_W-1:0] old_prd_addr_o,
  input  logic              cdb_en_i,
  input  logic [PREG_W-1:0] cdb_preg_i,
  input  logic              commit_en_i,
  input  logic [AREG_W-1:0] commit_areg_i,
  input  logic [PREG_W-1:0] commit_preg_i,
  input  logic [PREG_W-1:0] commit_old_preg_i,
  input  logic              flush_i,
  output logic [PREG_W:0]   fl_count_o
);

  localparam logic [PREG_W-1:0] PZERO = PREG_W'(PREG_ZERO);
  localparam logic [AREG_W-1:0] AZERO = {AREG_W{1'b0}};

  logic [PREG_W-1:0]    rat_q  [ARCH_REGS];
  logic [PREG_W-1:0]    rat_d  [ARCH_REGS];
  logic [PREG_W-1:0]    crat_q [ARCH_REGS];
  logic [PREG_W-1:0]    crat_d [ARCH_REGS];
  logic [PHYS_REGS-1:0] busy_q, busy_d;

  logic              alloc_req, fire, alloc, byp1, byp2;
  logic [PREG_W-1:0] fl_head, prs1, prs2;
  logic [PREG_W:0]   fl_count;

  assign alloc_req  = rd_wen_i & (rd_addr_i != AZERO);
  assign rn_ready_o = ~flush_i & ((fl_count != {(PREG_W + 1){1'b0}}) | ~alloc_req);
  assign fire       = rn_valid_i & rn_ready_o;
  assign alloc      = fire & alloc_req;

  // Lookups read pre-update state, so a source equal to rd sees the old mapping.
  assign prs1 = (rs1_addr_i == AZERO) ? PZERO : rat_q[rs1_addr_i];
  assign prs2 = (rs2_addr_i == AZERO) ? PZERO : rat_q[rs2_addr_i];

`ifdef RENAME_CDB_BYPASS_EN
  assign byp1 = cdb_en_i & (cdb_preg_i == prs1);
  assign byp2 = cdb_en_i & (cdb_preg_i == prs2);
`else
  assign byp1 = 1'b0;
  assign byp2 = 1'b0;
`endif

  assign prs1_addr_o    = prs1;
  assign prs2_addr_o    = prs2;
  assign prs1_rdy_o     = (rs1_addr_i == AZERO) | ~busy_q[prs1] | byp1;
  assign prs2_rdy_o     = (rs2_addr_i == AZERO) | ~busy_q[prs2] | byp2;
  assign prd_addr_o     = alloc ? fl_head : PZERO;
  assign old_prd_addr_o = alloc ? rat_q[rd_addr_i] : PZERO;
  assign fl_count_o     = fl_count;

  // Next map state; flush restores from the committed map including this cycle's commit.
  always_comb begin
    for (int i = 0; i < ARCH_REGS; i++) begin
      crat_d[i] = (commit_en_i && (commit_areg_i == AREG_W'(i))) ? commit_preg_i : crat_q[i];
      rat_d[i]  = flush_i ? crat_d[i]
                : ((alloc && (rd_addr_i == AREG_W'(i))) ? fl_head : rat_q[i]);
    end
    for (int i = 0; i < PHYS_REGS; i++) begin
      busy_d[i] = flush_i ? 1'b0
                : (alloc && (fl_head == PREG_W'(i))) ? 1'b1
                : (cdb_en_i && (cdb_preg_i == PREG_W'(i))) ? 1'b0
                : busy_q[i];
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < ARCH_REGS; i++) begin
        rat_q[i]  <= PREG_W'(i);
        crat_q[i] <= PREG_W'(i);
      end
      busy_q <= {PHYS_REGS{1'b0}};
    end else begin
      rat_q  <= rat_d;
      crat_q <= crat_d;
      busy_q <= busy_d;
    end
  end

  phys_freelist #(
    .DEPTH  (FL_DEPTH),
    .BASE   (ARCH_REGS),
    .PREG_W (PREG_W)
  ) u_freelist (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .pop_i       (alloc),
    .push_i      (commit_en_i),
    .push_data_i (commit_old_preg_i),
    .rollback_i  (flush_i),
    .head_data_o (fl_head),
    .count_o     (fl_count)
  );

endmodule
